// File: rtl/sprite_fetch.sv
// Read-side SRAM client: walks a req_w x req_h sprite row-major from req_base
// and streams pixels out over valid/ready, hiding the SRAM's 1-cycle read latency.
module sprite_fetch #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 16,
  parameter int W_BITS     = 8,
  parameter int H_BITS     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_base,
  input  logic [W_BITS-1:0]     req_w,
  input  logic [H_BITS-1:0]     req_h,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [W_BITS-1:0]     pix_col,
  output logic [H_BITS-1:0]     pix_row,
  output logic                  pix_last,
  output logic                  done
);

  localparam int TW = W_BITS + H_BITS + 1;
  localparam int EW = DATA_WIDTH + TW;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, last_addr_q;
  logic [W_BITS-1:0]     w_q, col_q;
  logic [H_BITS-1:0]     h_q, row_q;
  logic                  pending_q;
  logic [TW-1:0]         pend_tag_q;
  logic [EW-1:0]         fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic                  done_q;
  logic                  accept, zero_req, issue, pop, col_end, tag_last;
  logic [2:0]            occ;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign zero_req  = (req_w == '0) || (req_h == '0);
  assign col_end   = (col_q == w_q - W_BITS'(1));
  assign tag_last  = col_end && (row_q == h_q - H_BITS'(1));
  assign pix_valid = (count_q != 2'd0);
  assign pop       = pix_valid & pix_ready;
  // Slots already committed after this edge: stored entries plus the read in flight.
  assign occ       = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};

  assign {pix_data, pix_col, pix_row, pix_last} = fifo_q[rd_ptr_q];
  assign mem_en   = issue;
  assign mem_we   = 1'b0;
  assign mem_addr = issue ? addr_q : last_addr_q;
  assign done     = done_q;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (accept && !zero_req) state_nxt = FETCH;
      FETCH: begin
        issue = (occ <= 3'd1);
        if (issue && tag_last) state_nxt = DRAIN;
      end
      DRAIN: if (pop && pix_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, running address and pixel coordinates; the tag of each read
  // waits in pend_tag_q until its data returns from the SRAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pending_q   <= 1'b0;
      pend_tag_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_q    <= (accept && zero_req) || ((state == DRAIN) && pop && pix_last);
      pending_q <= issue;
      if (accept) begin
        addr_q <= req_base;
        w_q    <= req_w;
        h_q    <= req_h;
        col_q  <= '0;
        row_q  <= '0;
      end else if (issue) begin
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        last_addr_q <= addr_q;
        pend_tag_q  <= {col_q, row_q, tag_last};
        if (col_end) begin
          col_q <= '0;
          row_q <= row_q + H_BITS'(1);
        end else begin
          col_q <= col_q + W_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (pending_q) begin
        fifo_q[wr_ptr_q] <= {mem_data, pend_tag_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, pending_q} - {1'b0, pop};
    end
  end

endmodule
